// File: rtl/clock_div_mux.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_mux
// Purpose  : Programmable clock divider whose output fans out to NUM_OUT
//            individually gated channels. The divide ratio and the channel
//            enables are changed through a valid/ready handshake. A change
//            takes effect only at the rising point of the divided clock, so
//            no channel ever shows a runt or truncated pulse.
//
// Ports    : core_clock  - sole clock, rising edge
//            reset_n     - asynchronous active-low reset
//            cfg_div     - requested divide field D (half-period = D+1 cycles)
//            cfg_en      - requested per-channel enables
//            cfg_valid   - request strobe
//            cfg_ready   - high when a request can be accepted
//            clock_out   - gated divided clocks (registered)
//            active_div  - divide field currently in effect
//            active_en   - channel enables currently in effect
//
// Options  : CLOCK_DIV_MUX_CFG_SYNC_EN - when defined, cfg_valid passes through
//            a two-flop synchroniser and a rising-edge detector, so each 0->1
//            transition of the raw pin is one request (accept latency +2).
//            When undefined, cfg_valid is used directly as a level.
//
// Revision : 1.0 - initial release
// ============================================================================
module clock_div_mux #(
  parameter int unsigned              DIV_WIDTH = 8,
  parameter int unsigned              NUM_OUT   = 3,
  parameter logic [DIV_WIDTH-1:0]     RESET_DIV = '0,
  parameter logic [NUM_OUT-1:0]       RESET_EN  = '1
) (
  input  logic                        core_clock,
  input  logic                        reset_n,
  input  logic [DIV_WIDTH-1:0]        cfg_div,
  input  logic [NUM_OUT-1:0]          cfg_en,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  output logic [NUM_OUT-1:0]          clock_out,
  output logic [DIV_WIDTH-1:0]        active_div,
  output logic [NUM_OUT-1:0]          active_en
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0]           c_st_run  = 1'b0;
  localparam logic [0:0]           c_st_pend = 1'b1;
  localparam logic [DIV_WIDTH-1:0] c_cnt_one = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 r_div_clk;
  logic [DIV_WIDTH-1:0] r_active_div;
  logic [NUM_OUT-1:0]   r_active_en;
  logic [DIV_WIDTH-1:0] r_pend_div;
  logic [NUM_OUT-1:0]   r_pend_en;
  logic [0:0]           r_state;
  logic [0:0]           w_state_next;
  logic [NUM_OUT-1:0]   r_clock_out;

  logic                 w_req;
  logic                 w_terminal;
  logic                 w_rise;
  logic                 w_div_clk_next;
  logic                 w_accept;
  logic                 w_apply;
  logic                 w_ready;
  logic [DIV_WIDTH-1:0] w_active_div_next;
  logic [NUM_OUT-1:0]   w_active_en_next;

  // --------------------------------------------------------------------------
  // Request front end
  // --------------------------------------------------------------------------
`ifdef CLOCK_DIV_MUX_CFG_SYNC_EN
  logic r_sync_meta;
  logic r_sync_out;
  logic r_sync_dly;

  // Two synchroniser flops followed by a delay flop for edge detection; a
  // request is a single-cycle pulse on the 0->1 transition of the raw pin.
  always_ff @(posedge core_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_meta <= 1'b0;
      r_sync_out  <= 1'b0;
      r_sync_dly  <= 1'b0;
    end else begin
      r_sync_meta <= cfg_valid;
      r_sync_out  <= r_sync_meta;
      r_sync_dly  <= r_sync_out;
    end
  end

  assign w_req = r_sync_out & ~r_sync_dly;
`else
  assign w_req = cfg_valid;
`endif

  // --------------------------------------------------------------------------
  // Divider
  // --------------------------------------------------------------------------
  // The terminal count ends a half-period. A terminal cycle while the divided
  // clock is low is the rising point: the only instant at which a new ratio
  // or enable set may take effect.
  assign w_terminal     = (r_cnt == r_active_div);
  assign w_rise         = w_terminal & ~r_div_clk;
  assign w_div_clk_next = w_terminal ? ~r_div_clk : r_div_clk;

  always_ff @(posedge core_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_div_clk <= 1'b0;
    end else begin
      if (w_terminal) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
      r_div_clk <= w_div_clk_next;
    end
  end

  // --------------------------------------------------------------------------
  // Configuration FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge core_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_run;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Configuration FSM: next-state logic
  // --------------------------------------------------------------------------
  // A request accepted on a rising-point edge lands in PEND after that edge,
  // so it is applied at the following rising point, never the current one.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_run: begin
        if (w_req) begin
          w_state_next = c_st_pend;
        end
      end
      c_st_pend: begin
        if (w_rise) begin
          w_state_next = c_st_run;
        end
      end
      default: begin
        w_state_next = c_st_run;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Configuration FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_ready  = 1'b0;
    w_accept = 1'b0;
    w_apply  = 1'b0;
    case (r_state)
      c_st_run: begin
        w_ready  = 1'b1;
        w_accept = w_req;
      end
      c_st_pend: begin
        w_apply  = w_rise;
      end
      default: begin
        w_ready  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pending and active configuration
  // --------------------------------------------------------------------------
  always_ff @(posedge core_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_div <= '0;
      r_pend_en  <= '0;
    end else if (w_accept) begin
      r_pend_div <= cfg_div;
      r_pend_en  <= cfg_en;
    end
  end

  assign w_active_div_next = w_apply ? r_pend_div : r_active_div;
  assign w_active_en_next  = w_apply ? r_pend_en  : r_active_en;

  // The counter restarts at the application edge, so the new ratio governs
  // the high phase that begins there.
  always_ff @(posedge core_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_active_div <= RESET_DIV;
      r_active_en  <= RESET_EN;
    end else begin
      r_active_div <= w_active_div_next;
      r_active_en  <= w_active_en_next;
    end
  end

  // --------------------------------------------------------------------------
  // Gated output channels
  // --------------------------------------------------------------------------
  // Each channel is registered from the next divided-clock value so it rises
  // on the same edge as the divider. Enables only change at a rising point,
  // so a disabled channel still finishes its current high phase.
  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_chan
      always_ff @(posedge core_clock or negedge reset_n) begin
        if (!reset_n) begin
          r_clock_out[gi] <= 1'b0;
        end else begin
          r_clock_out[gi] <= w_div_clk_next & w_active_en_next[gi];
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output assignments
  // --------------------------------------------------------------------------
  assign cfg_ready  = w_ready;
  assign clock_out  = r_clock_out;
  assign active_div = r_active_div;
  assign active_en  = r_active_en;

endmodule
`default_nettype wire
